// File: rtl/pll_reset_pkg.sv
// pll_reset_pkg: shared state type, default parameters and width helper for the PLL reset sequencer.
package pll_reset_pkg;
  typedef enum logic [1:0] {WAIT_LOCK, HOLD, RUN} state_t;
  localparam int SYNC_STAGES_D = 2;
  localparam int HOLD_CYCLES_D = 1024;
  localparam int LOSS_FILTER_D = 4;
  localparam int CEN_DIV_D = 2;
  localparam int LOSS_COUNT_W = 8;
  function automatic int cw(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/pll_reset_sequencer_sync_bit.sv
// sync_bit: STAGES-deep flop chain bringing an asynchronous bit into the clk domain.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] r;
  always_ff @(posedge clk) r <= rst ? '0 : {r[STAGES-2:0], d};
  assign q = r[STAGES-1];
endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: lock-qualified system reset, ready flag and clock enable; define PLL_RESET_LOSS_COUNT_EN for loss_count.
module pll_reset_sequencer
  import pll_reset_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_D,
  parameter int HOLD_CYCLES = HOLD_CYCLES_D,
  parameter int LOSS_FILTER = LOSS_FILTER_D,
  parameter int CEN_DIV = CEN_DIV_D
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    locked,
  output logic                    sys_rst,
  output logic                    ready,
  output logic                    cen,
  output logic [LOSS_COUNT_W-1:0] loss_count
);
  localparam int HW = cw(HOLD_CYCLES);
  localparam int FW = cw(LOSS_FILTER);
  localparam int DW = cw(CEN_DIV);
  state_t state, state_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic [FW-1:0] filt_cnt, filt_n;
  logic [DW-1:0] div_cnt, div_n;
  logic sys_rst_n, ready_n, cen_n, locked_s, div_end;
  sync_bit #(.STAGES(SYNC_STAGES)) u_sync (.clk(clk), .rst(rst), .d(locked), .q(locked_s));
  assign div_end = div_cnt == DW'(CEN_DIV - 1);
  always_comb begin
    state_n = state;
    hold_n = hold_cnt;
    filt_n = filt_cnt;
    div_n = div_cnt;
    sys_rst_n = sys_rst;
    ready_n = ready;
    cen_n = 1'b0;
    case (state)
      WAIT_LOCK: begin
        sys_rst_n = 1'b1;
        ready_n = 1'b0;
        if (locked_s) begin
          state_n = HOLD;
          hold_n = '0;
        end
      end
      HOLD: begin
        hold_n = hold_cnt + 1'b1;
        if (!locked_s) state_n = WAIT_LOCK;
        else if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
          state_n = RUN;
          sys_rst_n = 1'b0;
          ready_n = 1'b1;
          div_n = '0;
          filt_n = '0;
        end
      end
      RUN: begin
        div_n = div_end ? '0 : div_cnt + 1'b1;
        cen_n = div_end;
        filt_n = locked_s ? '0 : filt_cnt + 1'b1;
        // a full filter's worth of low samples is a real loss, not a glitch
        if (!locked_s && filt_cnt == FW'(LOSS_FILTER - 1)) begin
          state_n = WAIT_LOCK;
          sys_rst_n = 1'b1;
          ready_n = 1'b0;
          cen_n = 1'b0;
          filt_n = '0;
        end
      end
      default: state_n = WAIT_LOCK;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WAIT_LOCK;
      hold_cnt <= '0;
      filt_cnt <= '0;
      div_cnt <= '0;
      sys_rst <= 1'b1;
      ready <= 1'b0;
      cen <= 1'b0;
    end else begin
      state <= state_n;
      hold_cnt <= hold_n;
      filt_cnt <= filt_n;
      div_cnt <= div_n;
      sys_rst <= sys_rst_n;
      ready <= ready_n;
      cen <= cen_n;
    end
  end
`ifdef PLL_RESET_LOSS_COUNT_EN
  logic [LOSS_COUNT_W-1:0] lc;
  always_ff @(posedge clk) begin
    if (rst) lc <= '0;
    else if (state == RUN && state_n == WAIT_LOCK && lc != '1) lc <= lc + 1'b1;
  end
  assign loss_count = lc;
`else
  assign loss_count = '0;
`endif
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: randomized and directed checks against a run-length behavioural model.
module tb_pll_reset_sequencer;
  localparam int S = 2, H = 16, L = 4, D = 2;
`ifdef PLL_RESET_LOSS_COUNT_EN
  localparam int LC_EN = 1;
`else
  localparam int LC_EN = 0;
`endif
  logic clk = 0, rst = 1, locked = 0;
  logic sys_rst, ready, cen;
  logic [7:0] loss_count;
  int checks = 0, errors = 0;
  pll_reset_sequencer #(.SYNC_STAGES(S), .HOLD_CYCLES(H), .LOSS_FILTER(L), .CEN_DIV(D)) dut (
    .clk(clk), .rst(rst), .locked(locked), .sys_rst(sys_rst), .ready(ready), .cen(cen),
    .loss_count(loss_count));
  always #5 clk = ~clk;

  // model: release after H+1 consecutive synced-high edges, loss after L consecutive synced-low edges in run
  logic m_run = 0, m_cen = 0, go = 0;
  int ones = 0, zeros = 0, k = 0, mloss = 0;
  logic hist[$];
  always @(posedge clk) begin
    logic ls;
    if (rst) begin
      m_run = 0; m_cen = 0; ones = 0; zeros = 0; k = 0; mloss = 0; go = 1;
      hist.delete();
      for (int i = 0; i < S; i++) hist.push_back(1'b0);
    end else begin
      ls = hist[S-1];
      hist.push_front(locked);
      void'(hist.pop_back());
      m_cen = 0;
      if (!m_run) begin
        ones = ls ? ones + 1 : 0;
        if (ones == H + 1) begin m_run = 1; k = 0; zeros = 0; ones = 0; end
      end else begin
        zeros = ls ? 0 : zeros + 1;
        if (zeros == L) begin
          m_run = 0; ones = 0;
          if (LC_EN == 1 && mloss < 255) mloss++;
        end else begin
          k++;
          m_cen = (k % D == 0);
        end
      end
    end
  end

  always @(negedge clk) if (go) begin
    checks++;
    if (sys_rst !== !m_run || ready !== m_run || cen !== m_cen || loss_count !== 8'(mloss)) begin
      errors++;
      $display("FAIL cycle t=%0t got sys_rst=%b ready=%b cen=%b loss=%0d want %b %b %b %0d",
               $time, sys_rst, ready, cen, loss_count, !m_run, m_run, m_cen, mloss);
    end
  end

  task automatic measure(input logic want, input int exp, input string nm);
    int n = 0;
    do begin @(posedge clk); #1; n++; end while (sys_rst !== want && n < 200);
    checks++;
    if (n != exp) begin errors++; $display("FAIL %s edges=%0d want=%0d", nm, n, exp); end
  endtask

  task automatic lit(input int got, input int exp, input string nm);
    checks++;
    if (got != exp) begin errors++; $display("FAIL %s got=%0d want=%0d", nm, got, exp); end
  endtask

  initial begin
    repeat (5) @(negedge clk);
    lit(sys_rst, 1, "reset_sys_rst");
    lit(ready + cen + loss_count, 0, "reset_outs");
    rst = 0;
    locked = 1;
    measure(1'b0, S + 1 + H, "lock_release");
    lit(ready, 1, "ready_at_release");
    repeat (4) @(negedge clk);
    locked = 0;
    repeat (3) @(negedge clk);
    locked = 1;
    repeat (12) @(negedge clk);
    lit(ready, 1, "glitch_ready");
    lit(loss_count, 0, "glitch_loss");
    locked = 0;
    measure(1'b1, S + L, "loss_latency");
    repeat (9) @(negedge clk);
    lit(loss_count, LC_EN, "loss_count_1");
    lit(cen, 0, "cen_after_loss");
    locked = 1;
    measure(1'b0, S + 1 + H, "relock_release");
    @(negedge clk);
    locked = 0;
    repeat (20) @(negedge clk);
    locked = 1;
    repeat (S + 8) @(negedge clk);
    locked = 0;
    repeat (30) @(negedge clk);
    lit(sys_rst, 1, "hold_loss_sys_rst");
    lit(loss_count, LC_EN, "hold_loss_count");
    locked = 1;
    measure(1'b0, S + 1 + H, "hold_retry_release");
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      locked = 1; repeat (22) @(negedge clk);
      locked = 0; repeat (8) @(negedge clk);
    end
    lit(loss_count, 3 * LC_EN, "loss_count_3");
    locked = 1;
    measure(1'b0, S + 1 + H, "pre_rst_release");
    @(negedge clk);
    rst = 1;
    @(posedge clk); #1;
    lit(sys_rst, 1, "rst_mid_run_sys_rst");
    lit(loss_count, 0, "rst_mid_run_loss");
    @(negedge clk);
    rst = 0;
    measure(1'b0, S + 1 + H, "rst_release");
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 15) == 0) begin rst = 1; @(negedge clk); rst = 0; end
      locked = $urandom_range(0, 1);
      repeat ($urandom_range(1, 30)) @(negedge clk);
    end
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 260; i++) begin
      locked = 1; repeat (20) @(negedge clk);
      locked = 0; repeat (7) @(negedge clk);
    end
    lit(loss_count, 255 * LC_EN, "loss_saturation");
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Consumer end of the PLL interface: takes the asynchronous `locked` flag and runs on the PLL output clock (`outclk_0`, 12 MHz).
- Generates a clean synchronous system reset, a "ready" flag and a divided clock enable for downstream logic.
- Debounces loss of lock: a glitch shorter than the filter length is ignored; a sustained loss re-asserts reset and restarts the sequence.

Parameters:
- SYNC_STAGES, 2: flops in the `locked` synchroniser (min 2).
- HOLD_CYCLES, 1024: clocks `sys_rst` stays high after `locked` is seen stable (min 1).
- LOSS_FILTER, 4: consecutive low samples of synced `locked` needed to declare loss of lock (min 1).
- CEN_DIV, 2: clock-enable divide ratio; `cen` pulses once every CEN_DIV clocks (min 2).

Ports:
- clk  in  1  PLL output clock (`outclk_0`); sole clock domain.
- rst  in  1  synchronous, active-high reset.
- locked  in  1  PLL lock flag; asynchronous to clk.
- sys_rst  out  1  synchronous active-high reset to the system.
- ready  out  1  high while sequencer is in RUN.
- cen  out  1  single-cycle clock-enable pulse, active only in RUN.
- loss_count  out  8  saturating count of loss-of-lock events since rst.

Behaviour:
- Interface (decided): one clock `clk`; `rst` is synchronous and active-high, with priority over all other logic.
- Reset values: `sys_rst`=1, `ready`=0, `cen`=0, `loss_count`=0, state=WAIT_LOCK, all counters 0.
- Outputs: all registered; no combinational path from `locked` to any output.
- Synchroniser: `locked_s` = `locked` delayed by SYNC_STAGES flops.
- State WAIT_LOCK:
  - `sys_rst`=1, `ready`=0.
  - When `locked_s`=1, go to HOLD with hold_cnt=0.
- State HOLD:
  - `sys_rst`=1; hold_cnt increments each clock.
  - If `locked_s`=0, go to WAIT_LOCK; `loss_count` is not incremented.
  - Else, when hold_cnt==HOLD_CYCLES-1, go to RUN.
  - On that same edge: `sys_rst`←0, `ready`←1, div_cnt←0, filt_cnt←0.
- State RUN:
  - div_cnt counts 0..CEN_DIV-1 and wraps.
  - `cen`←1 on the edge where div_cnt==CEN_DIV-1, else 0.
  - The first `cen` pulse is high during the CEN_DIV-th clock after `sys_rst` falls.
- Loss filter (RUN only):
  - When `locked_s`=1, filt_cnt←0.
  - When `locked_s`=0 and filt_cnt<LOSS_FILTER-1, filt_cnt increments.
  - When `locked_s`=0 and filt_cnt==LOSS_FILTER-1, go to WAIT_LOCK on that edge: `sys_rst`←1, `ready`←0, `cen`←0, `loss_count` increments (saturates at 255).
- Latency, lock to release: `sys_rst` falls SYNC_STAGES+1+HOLD_CYCLES edges after the first edge that samples `locked`=1 (1027 with defaults).
- Latency, loss to reset: `sys_rst` rises SYNC_STAGES+LOSS_FILTER edges after the first edge that samples `locked`=0 (6 with defaults).
- Glitch: a low pulse of `locked_s` shorter than LOSS_FILTER clocks causes no output change, and `cen` cadence continues undisturbed.
- `rst` mid-RUN: next edge returns to the reset values, including `loss_count`=0.
- Sequence restarts: each new lock runs the full HOLD again.
- Counter widths: clog2 of the respective parameter, min 1 bit.

Optional Feature:
- Macro: PLL_RESET_LOSS_COUNT_EN.
- Defined: `loss_count` is implemented as above.
- Undefined: `loss_count` is constant 0 and no counter is synthesised; all other behaviour is identical.

Decomposition:
- Package pll_reset_pkg holds:
  - state enum typedef (WAIT_LOCK, HOLD, RUN);
  - default parameter constants;
  - LOSS_COUNT_W=8.
- One sub-module is natural: sync_bit, a parameterised SYNC_STAGES-deep flop chain for `locked`, reusable elsewhere.
- Remaining FSM, counters and divider stay in the top.

Test Plan (HOLD_CYCLES=16, LOSS_FILTER=4, CEN_DIV=2 unless noted):
- Power-up: assert `rst` 5 clocks, `locked`=0 → `sys_rst`=1, `ready`=0, `cen`=0, `loss_count`=0 throughout. Raise `locked` → `sys_rst` falls exactly 19 edges later; `ready` rises on the same edge; `cen` alternates 0,1 starting with 1 on the 2nd clock after release.
- Lock lost during HOLD: drop `locked` 8 clocks after it is synced → return to WAIT_LOCK, `sys_rst` never falls, `loss_count` stays 0. Re-raise → full 19-edge sequence again.
- Glitch in RUN: `locked` low for 3 clocks → `sys_rst`, `ready` and `cen` cadence unchanged; `loss_count`=0.
- Sustained loss in RUN: `locked` low for 10 clocks → `sys_rst`=1 and `ready`=0 exactly 6 edges after the first low sample; `cen`=0; `loss_count`=1. Relock → release 19 edges later.
- Saturation (PLL_RESET_LOSS_COUNT_EN defined) → after 260 loss/relock cycles `loss_count`=255. With the macro undefined, `loss_count`=0 throughout.
- Reset mid-RUN: assert `rst` 1 clock with `loss_count`=3 → next edge `sys_rst`=1, `loss_count`=0, state WAIT_LOCK. With `locked` still high, release follows 19 edges after `rst` drops.
